image_rom_arbiter: RTL and testbench

IMAGE_ROM_ARBITER -- requirements
Module: image_rom_arbiter

---
 rtl/image_rom_arbiter_if.sv | 44 ++++
 rtl/image_rom_arbiter.sv | 115 +++++++++++
 tb/tb_image_rom_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/image_rom_arbiter_if.sv
// ---------------------------------------------------------------------------
// image_rom_arbiter_if
// Bundle of the request, ROM and return signals around image_rom_arbiter.
//
// Handshake: a requester raises reqN with a stable addrN. The arbiter answers
// combinationally with gntN in the same cycle. The request is consumed at the
// rising edge that ends a cycle in which both reqN and gntN are high. Requests
// are not queued, so an ungranted requester keeps reqN high until it sees
// gntN. Each grant produces exactly one rd_validN strobe, with rd_dataN, a
// fixed number of cycles later. There is no back-pressure on the return side.
//
// Modports
//   slave  : arbiter view (requests and rom_data in; grants, rom_addr and
//            returns out)
//   master : requester/ROM side view (the mirror image)
// ---------------------------------------------------------------------------
interface image_rom_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic              prio0;
  logic              gnt0;
  logic              gnt1;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              rd_valid0;
  logic              rd_valid1;
  logic [DATA_W-1:0] rd_data0;
  logic [DATA_W-1:0] rd_data1;

  modport slave (
    input  req0, req1, addr0, addr1, prio0, rom_data,
    output gnt0, gnt1, rom_addr, rd_valid0, rd_valid1, rd_data0, rd_data1
  );

  modport master (
    output req0, req1, addr0, addr1, prio0, rom_data,
    input  gnt0, gnt1, rom_addr, rd_valid0, rd_valid1, rd_data0, rd_data1
  );
endinterface

// File: rtl/image_rom_arbiter.sv
// ---------------------------------------------------------------------------
// image_rom_arbiter
// Shares one single-port image ROM between the display pixel path
// (requester 0) and a secondary sprite/overlay fetch (requester 1).
// At most one read is granted per cycle, and full throughput is sustained.
// Requester 0 wins outright while prio0 is high (active video). Otherwise
// ties go round-robin using a one-bit last-grant pointer.
//
// Ports
//   pixel_clk : sole clock, rising edge
//   reset_n   : asynchronous active-low reset
//   bus       : image_rom_arbiter_if.slave. This carries req0/1 and addr0/1,
//               prio0, the combinational gnt0/1, the registered rom_addr,
//               the ROM's rom_data, and the registered rd_valid0/1 and
//               rd_data0/1 return strobes.
//
// Timing: for a grant in cycle T, rom_addr is loaded at the end of T. The
// ROM data is valid ROM_LAT cycles after that. The return strobe is
// registered once more, so rd_validN is seen in cycle T+2+ROM_LAT.
// ---------------------------------------------------------------------------
module image_rom_arbiter #(
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1   // ROM read latency in clocks, 1..4
) (
  input  logic                pixel_clk,
  input  logic                reset_n,
  image_rom_arbiter_if.slave  bus
);

  logic              last_q;       // index of the most recent grant
  logic              gnt0;
  logic              gnt1;
  logic              gnt_any;
  logic [ADDR_W-1:0] rom_addr_q;

  // Tag pipeline: slot k holds the grant issued k+1 cycles ago. Slot ROM_LAT
  // lines up with the cycle in which rom_data belongs to that grant.
  logic [ROM_LAT:0]  tag_vld_q;
  logic [ROM_LAT:0]  tag_own_q;

  logic              rd_valid0_q;
  logic              rd_valid1_q;
  logic [DATA_W-1:0] rd_data0_q;
  logic [DATA_W-1:0] rd_data1_q;

  // Grant decode. Grants are gated by reset_n so that nothing is granted
  // while the block is held in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset_n) begin
      if (bus.req0 && bus.req1) begin
        // Tie: prio0 forces requester 0. Otherwise the one not granted last
        // wins.
        if (bus.prio0 || last_q) gnt0 = 1'b1;
        else                     gnt1 = 1'b1;
      end else begin
        gnt0 = bus.req0;
        gnt1 = bus.req1;
      end
    end
  end

  assign gnt_any = gnt0 | gnt1;

  // Pointer and ROM address only move on a grant edge. The pointer resets to
  // 1 so that requester 0 takes the first tie after reset.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q     <= 1'b1;
      rom_addr_q <= '0;
    end else if (gnt_any) begin
      last_q     <= gnt1;
      rom_addr_q <= gnt1 ? bus.addr1 : bus.addr0;
    end
  end

  // The tag pipeline shifts every cycle and never stalls. Reset clears all
  // valid bits, which discards any reads still in flight.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_vld_q <= '0;
      tag_own_q <= '0;
    end else begin
      tag_vld_q <= {tag_vld_q[ROM_LAT-1:0], gnt_any};
      tag_own_q <= {tag_own_q[ROM_LAT-1:0], gnt1};
    end
  end

  // Return stage. Return data registers only load on their own strobe, so
  // each keeps the last value returned to its owner.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid0_q <= 1'b0;
      rd_valid1_q <= 1'b0;
      rd_data0_q  <= '0;
      rd_data1_q  <= '0;
    end else begin
      rd_valid0_q <= tag_vld_q[ROM_LAT] & ~tag_own_q[ROM_LAT];
      rd_valid1_q <= tag_vld_q[ROM_LAT] &  tag_own_q[ROM_LAT];
      if (tag_vld_q[ROM_LAT] && !tag_own_q[ROM_LAT]) rd_data0_q <= bus.rom_data;
      if (tag_vld_q[ROM_LAT] &&  tag_own_q[ROM_LAT]) rd_data1_q <= bus.rom_data;
    end
  end

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.rd_valid0 = rd_valid0_q;
  assign bus.rd_valid1 = rd_valid1_q;
  assign bus.rd_data0  = rd_data0_q;
  assign bus.rd_data1  = rd_data1_q;

endmodule

// File: tb/tb_image_rom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_image_rom_arbiter
// Directed bench for image_rom_arbiter. u_dut1 uses ROM_LAT = 1 and u_dut3
// uses ROM_LAT = 3. Each instance is fed by a behavioural ROM pipeline of
// matching latency. The bench ends with a long randomised run against a
// reference arbiter and an expected-return queue.
// ---------------------------------------------------------------------------
module tb_image_rom_arbiter;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;
  localparam int EW     = 32 + 1 + DATA_W;   // {due cycle, owner, data}

  logic pixel_clk;
  logic reset_n;

  int checks   = 0;
  int failures = 0;

  image_rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();
  image_rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus3 ();

  image_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(1)) u_dut1 (
    .pixel_clk (pixel_clk),
    .reset_n   (reset_n),
    .bus       (bus1.slave)
  );

  image_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(3)) u_dut3 (
    .pixel_clk (pixel_clk),
    .reset_n   (reset_n),
    .bus       (bus3.slave)
  );

  // ---------------- clock ----------------
  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  // ---------------- ROM content and models ----------------
  function automatic logic [DATA_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ a[15:8] ^ {7'b0, a[16]} ^ 8'h5A;
  endfunction

  logic [DATA_W-1:0] rom1_q;
  logic [DATA_W-1:0] rom3_q [3];

  always @(posedge pixel_clk) begin
    rom1_q    <= rom_f(bus1.rom_addr);
    rom3_q[0] <= rom_f(bus3.rom_addr);
    rom3_q[1] <= rom3_q[0];
    rom3_q[2] <= rom3_q[1];
  end

  assign bus1.rom_data = rom1_q;
  assign bus3.rom_data = rom3_q[2];

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge pixel_clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt0"},   32'(bus1.gnt0),      0);
    check({tag, "_gnt1"},   32'(bus1.gnt1),      0);
    check({tag, "_addr"},   32'(bus1.rom_addr),  0);
    check({tag, "_vld0"},   32'(bus1.rd_valid0), 0);
    check({tag, "_vld1"},   32'(bus1.rd_valid1), 0);
    check({tag, "_dat0"},   32'(bus1.rd_data0),  0);
    check({tag, "_dat1"},   32'(bus1.rd_data1),  0);
  endtask

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q [$];

  // ---------------- stimulus ----------------
  initial begin
    logic [EW-1:0]     e;
    logic              mg0, mg1, m_last;
    logic [ADDR_W-1:0] ga;
    logic              exp_own [4];
    int                cyc;
    int                k;
    logic              o;

    exp_own = '{1'b0, 1'b1, 1'b0, 1'b1};

    reset_n    = 1'b0;
    bus1.req0  = 1'b1;  bus1.req1 = 1'b1;  bus1.prio0 = 1'b0;
    bus1.addr0 = 17'h0AAAA;  bus1.addr1 = 17'h05555;
    bus3.req0  = 1'b0;  bus3.req1 = 1'b0;  bus3.prio0 = 1'b0;
    bus3.addr0 = '0;    bus3.addr1 = '0;

    // Reset state: requests held high must still see no grant.
    repeat (2) tick();
    sample();
    check_all_zero("rst");
    check("rst_dut3_gnt1", 32'(bus3.gnt1), 0);

    tick();
    reset_n = 1'b1;  bus1.req0 = 1'b0;  bus1.req1 = 1'b0;

    // Single read by requester 0 at 0x00123.
    tick();  bus1.req0 = 1'b1;  bus1.addr0 = 17'h00123;
    sample();
    check("single_gnt0", 32'(bus1.gnt0), 1);
    check("single_gnt1", 32'(bus1.gnt1), 0);
    tick();  bus1.req0 = 1'b0;  bus1.addr0 = 17'h1FFFF;
    sample();
    check("single_romaddr", 32'(bus1.rom_addr), 32'h00123);
    check("idle_gnt0",      32'(bus1.gnt0), 0);
    check("idle_gnt1",      32'(bus1.gnt1), 0);
    check("single_t1_vld0", 32'(bus1.rd_valid0), 0);
    tick();  sample();
    check("single_t2_vld0", 32'(bus1.rd_valid0), 0);
    tick();  sample();
    check("single_t3_vld0", 32'(bus1.rd_valid0), 1);
    check("single_t3_dat0", 32'(bus1.rd_data0), 32'(rom_f(17'h00123)));
    check("single_t3_vld1", 32'(bus1.rd_valid1), 0);
    tick();  sample();
    check("single_t4_vld0", 32'(bus1.rd_valid0), 0);
    check("single_hold0",   32'(bus1.rd_data0), 32'(rom_f(17'h00123)));

    // Sole requester 1 wins even with prio0 high.
    tick();  bus1.req1 = 1'b1;  bus1.addr1 = 17'h00010;  bus1.prio0 = 1'b1;
    sample();
    check("sole1_gnt1", 32'(bus1.gnt1), 1);
    check("sole1_gnt0", 32'(bus1.gnt0), 0);
    tick();  bus1.req1 = 1'b0;  bus1.prio0 = 1'b0;
    sample();
    check("sole1_romaddr", 32'(bus1.rom_addr), 32'h00010);
    tick();  tick();  sample();
    check("sole1_vld1", 32'(bus1.rd_valid1), 1);
    check("sole1_dat1", 32'(bus1.rd_data1), 32'(rom_f(17'h00010)));
    check("sole1_vld0", 32'(bus1.rd_valid0), 0);

    // Round-robin tie for four cycles; the pointer currently holds 1.
    for (int i = 0; i < 8; i++) begin
      tick();
      bus1.req0  = (i < 4);  bus1.req1 = (i < 4);  bus1.prio0 = 1'b0;
      bus1.addr0 = 17'(32'h100 + i);  bus1.addr1 = 17'(32'h180 + i);
      sample();
      if (i < 4) begin
        check("rr_gnt0", 32'(bus1.gnt0), 32'(!exp_own[i]));
        check("rr_gnt1", 32'(bus1.gnt1), 32'(exp_own[i]));
      end
      if (i >= 3 && i < 7) begin
        k = i - 3;
        o = exp_own[k];
        check("rr_vld0", 32'(bus1.rd_valid0), 32'(!o));
        check("rr_vld1", 32'(bus1.rd_valid1), 32'(o));
        if (o) check("rr_dat1", 32'(bus1.rd_data1), 32'(rom_f(17'(32'h180 + k))));
        else   check("rr_dat0", 32'(bus1.rd_data0), 32'(rom_f(17'(32'h100 + k))));
      end
      if (i == 7) begin
        check("rr_end_vld0", 32'(bus1.rd_valid0), 0);
        check("rr_end_vld1", 32'(bus1.rd_valid1), 0);
      end
    end

    // prio0 for four cycles, then a tie without prio0 goes to requester 1.
    for (int i = 0; i < 5; i++) begin
      tick();
      bus1.req0  = 1'b1;  bus1.req1 = 1'b1;  bus1.prio0 = (i < 4);
      bus1.addr0 = 17'(32'h200 + i);  bus1.addr1 = 17'(32'h280 + i);
      sample();
      check("prio_gnt0", 32'(bus1.gnt0), 32'(i < 4));
      check("prio_gnt1", 32'(bus1.gnt1), 32'(i == 4));
    end
    tick();  bus1.req0 = 1'b0;  bus1.req1 = 1'b0;  bus1.prio0 = 1'b0;
    tick();  tick();  sample();
    check("prio_ret_vld1", 32'(bus1.rd_valid1), 1);
    check("prio_ret_dat1", 32'(bus1.rd_data1), 32'(rom_f(17'h00284)));
    check("prio_ret_vld0", 32'(bus1.rd_valid0), 0);
    repeat (3) tick();

    // Two grants, then reset pulsed while both reads are still in flight.
    tick();  bus1.req0 = 1'b1;  bus1.addr0 = 17'h00055;
    sample();
    check("flush_gnt0", 32'(bus1.gnt0), 1);
    tick();  bus1.req0 = 1'b0;  bus1.req1 = 1'b1;  bus1.addr1 = 17'h00066;
    sample();
    check("flush_gnt1", 32'(bus1.gnt1), 1);
    tick();  reset_n = 1'b0;  bus1.req0 = 1'b1;  bus1.req1 = 1'b1;
    sample();
    check_all_zero("flush_rst");
    tick();  reset_n = 1'b1;  bus1.req0 = 1'b0;  bus1.req1 = 1'b0;
    sample();
    check("flush_a_vld0", 32'(bus1.rd_valid0), 0);
    check("flush_a_vld1", 32'(bus1.rd_valid1), 0);
    for (int i = 0; i < 4; i++) begin
      tick();  sample();
      check("flush_b_vld0", 32'(bus1.rd_valid0), 0);
      check("flush_b_vld1", 32'(bus1.rd_valid1), 0);
    end
    tick();  bus1.req0 = 1'b1;  bus1.req1 = 1'b1;  bus1.prio0 = 1'b0;
    sample();
    check("post_rst_tie_gnt0", 32'(bus1.gnt0), 1);
    check("post_rst_tie_gnt1", 32'(bus1.gnt1), 0);
    tick();  bus1.req0 = 1'b0;  bus1.req1 = 1'b0;

    // ROM_LAT = 3: eight back-to-back reads by requester 1 at addresses 0..7.
    for (int i = 0; i < 14; i++) begin
      tick();
      bus3.req1  = (i < 8);
      bus3.addr1 = 17'(i);
      sample();
      if (i < 8) check("lat3_gnt1", 32'(bus3.gnt1), 1);
      if (i >= 5 && i < 13) begin
        check("lat3_vld1", 32'(bus3.rd_valid1), 1);
        check("lat3_dat1", 32'(bus3.rd_data1), 32'(rom_f(17'(i - 5))));
      end
      if (i == 4 || i == 13) check("lat3_edge_vld1", 32'(bus3.rd_valid1), 0);
      check("lat3_vld0", 32'(bus3.rd_valid0), 0);
    end

    // Randomised run against a reference arbiter from a clean reset.
    tick();  reset_n = 1'b0;
    tick();  reset_n = 1'b1;
    m_last = 1'b1;
    cyc    = 0;
    exp_q.delete();
    for (int i = 0; i < 10005; i++) begin
      tick();
      cyc++;
      if (i < 10000) begin
        bus1.req0  = 1'($urandom_range(0, 1));
        bus1.req1  = 1'($urandom_range(0, 1));
        bus1.prio0 = 1'($urandom_range(0, 1));
        bus1.addr0 = 17'($urandom_range(0, 32'h1FFFF));
        bus1.addr1 = 17'($urandom_range(0, 32'h1FFFF));
      end else begin
        bus1.req0 = 1'b0;  bus1.req1 = 1'b0;
      end
      sample();
      mg0 = 1'b0;  mg1 = 1'b0;
      if (bus1.req0 && bus1.req1) begin
        if (bus1.prio0 || m_last) mg0 = 1'b1;
        else                      mg1 = 1'b1;
      end else begin
        mg0 = bus1.req0;  mg1 = bus1.req1;
      end
      check("rnd_gnt0", 32'(bus1.gnt0), 32'(mg0));
      check("rnd_gnt1", 32'(bus1.gnt1), 32'(mg1));
      if (exp_q.size() > 0 && exp_q[0][EW-1 -: 32] == 32'(cyc)) begin
        e = exp_q.pop_front();
        o = e[DATA_W];
        check("rnd_vld0", 32'(bus1.rd_valid0), 32'(!o));
        check("rnd_vld1", 32'(bus1.rd_valid1), 32'(o));
        if (o) check("rnd_dat1", 32'(bus1.rd_data1), 32'(e[DATA_W-1:0]));
        else   check("rnd_dat0", 32'(bus1.rd_data0), 32'(e[DATA_W-1:0]));
      end else begin
        check("rnd_idle_vld0", 32'(bus1.rd_valid0), 0);
        check("rnd_idle_vld1", 32'(bus1.rd_valid1), 0);
      end
      if (mg0 || mg1) begin
        ga = mg1 ? bus1.addr1 : bus1.addr0;
        exp_q.push_back({32'(cyc + 3), mg1, rom_f(ga)});
        m_last = mg1;
      end
    end
    check("rnd_queue_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
